// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a one-word output buffer and valid/ready handshake.
// Bit order into the word is selected by MSB_FIRST.
module serial_word_assembler #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  sr_shift;
    logic              out_xfer;
    logic              out_free;

    assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
    assign out_xfer = valid_q && out_ready;
    assign out_free = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (out_xfer) begin
            valid_d = 1'b0;
        end
        unique case (state_q)
            StCollect: begin
                if (flush) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == LastCnt) begin
                        if (out_free) begin
                            // A word loaded here also replaces one leaving on this edge.
                            data_d  = sr_shift;
                            valid_d = 1'b1;
                            sr_d    = '0;
                            cnt_d   = '0;
                        end else begin
                            // Park the finished word in sr; bit_cnt keeps reading WIDTH-1.
                            sr_d    = sr_shift;
                            state_d = StHold;
                        end
                    end else begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (flush) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = StCollect;
                end else if (out_xfer) begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == StCollect);
    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign bit_cnt   = cnt_q;

endmodule
